// File: rtl/enemy_tank_ai.sv
// Autonomous enemy tank driver: LFSR-steered straight runs with pauses,
// escape from blocked moves, periodic and line-of-sight fire.
module enemy_tank_ai #(
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          SPAWN_DELAY = 60,
    parameter int          MIN_RUN     = 32,
    parameter int          PAUSE_LEN   = 4,
    parameter int          BLOCK_LIMIT = 2,
    parameter int          FIRE_PERIOD = 90,
    parameter int          ALIGN_TOL   = 8
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       enable,
    input  logic       dead,
    input  logic       got_hit,
    input  logic       blocked,
    input  logic [9:0] tank_x,
    input  logic [9:0] tank_y,
    input  logic [3:0] tank_dir,
    input  logic       bullet_active,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic       move_up,
    output logic       move_down,
    output logic       move_left,
    output logic       move_right,
    output logic       fire,
    output logic [1:0] ai_state
);

    typedef enum logic [1:0] {
        SPAWN_WAIT = 2'd0,
        DRIVE      = 2'd1,
        PAUSE      = 2'd2
    } state_t;

    localparam logic [15:0] SEED_I  = (SEED == 16'h0) ? 16'hACE1 : SEED;
    localparam logic [7:0]  SPAWN_L = 8'(SPAWN_DELAY);
    localparam logic [7:0]  PAUSE_L = 8'(PAUSE_LEN);
    localparam logic [7:0]  FIRE_L  = 8'(FIRE_PERIOD);
    localparam logic [7:0]  FIRE_H  = 8'(FIRE_PERIOD / 2);
    localparam logic [8:0]  RUN_MIN = 9'(MIN_RUN);
    localparam logic [4:0]  BLK_L   = 5'(BLOCK_LIMIT);
    localparam logic [10:0] TOL     = 11'(ALIGN_TOL);

    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic [7:0]  spawn_cnt;
    logic [7:0]  pause_cnt;
    logic [7:0]  fire_cnt;
    logic [7:0]  fire_dec;
    logic [8:0]  run_cnt;
    logic [8:0]  run_load;
    logic [3:0]  blk_cnt;
    logic [3:0]  blk_inc;
    logic [1:0]  dir;
    logic [1:0]  rdir;
    logic [1:0]  pdir;
    logic        exit_blk;
    logic [3:0]  mv;
    logic        blk_exit;
    logic        los;
    logic        fire_go;
    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] adx;
    logic [10:0] ady;

    function automatic logic [3:0] onehot(input logic [1:0] d);
        return 4'b0001 << d;
    endfunction

    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign rdir     = lfsr[1:0];
    assign run_load = RUN_MIN + {2'b00, lfsr[6:0]};
    assign pdir     = (exit_blk && rdir == dir) ? dir + 2'd1 : rdir;
    assign blk_exit = ({1'b0, blk_cnt} + {4'b0000, blocked}) >= BLK_L;
    assign blk_inc  = (blk_cnt == 4'hF) ? blk_cnt : blk_cnt + 4'd1;

    assign dx  = {1'b0, player_x} - {1'b0, tank_x};
    assign dy  = {1'b0, player_y} - {1'b0, tank_y};
    assign adx = dx[10] ? (~dx + 11'd1) : dx;
    assign ady = dy[10] ? (~dy + 11'd1) : dy;

    assign los =
        ((adx <= TOL) &&
         ((tank_dir == 4'b0001 && dy[10]) ||
          (tank_dir == 4'b0010 && !dy[10] && dy != 11'd0))) ||
        ((ady <= TOL) &&
         ((tank_dir == 4'b0100 && dx[10]) ||
          (tank_dir == 4'b1000 && !dx[10] && dx != 11'd0)));

    // Fire decisions look at the count after this frame's decrement,
    // so shots land exactly FIRE_PERIOD frames apart.
    assign fire_dec = (fire_cnt == 8'd0) ? 8'd0 : fire_cnt - 8'd1;
    assign fire_go  = !bullet_active && !fire &&
                      (fire_dec == 8'd0 || (los && fire_dec <= FIRE_H));

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state     <= SPAWN_WAIT;
            spawn_cnt <= SPAWN_L;
            dir       <= 2'b00;
            exit_blk  <= 1'b0;
            run_cnt   <= 9'd0;
            pause_cnt <= 8'd0;
            blk_cnt   <= 4'd0;
            fire_cnt  <= FIRE_L;
            lfsr      <= SEED_I;
            mv        <= 4'b0000;
            fire      <= 1'b0;
        end else if (!enable) begin
            mv   <= 4'b0000;
            fire <= 1'b0;
        end else begin
            lfsr <= lfsr_nxt;
            mv   <= 4'b0000;
            fire <= 1'b0;
            if (dead) begin
                state     <= SPAWN_WAIT;
                spawn_cnt <= SPAWN_L;
            end else if (got_hit) begin
                state     <= SPAWN_WAIT;
                spawn_cnt <= SPAWN_L;
                fire_cnt  <= FIRE_L;
            end else begin
                if (state != SPAWN_WAIT) begin
                    fire     <= fire_go;
                    fire_cnt <= fire_go ? FIRE_L : fire_dec;
                end
                unique case (state)
                    SPAWN_WAIT: begin
                        if (spawn_cnt <= 8'd1) begin
                            state   <= DRIVE;
                            dir     <= rdir;
                            run_cnt <= run_load;
                            blk_cnt <= 4'd0;
                            mv      <= onehot(rdir);
                        end else begin
                            spawn_cnt <= spawn_cnt - 8'd1;
                        end
                    end
                    DRIVE: begin
                        run_cnt <= run_cnt - 9'd1;
                        blk_cnt <= blocked ? blk_inc : 4'd0;
                        if (blk_exit) begin
                            state     <= PAUSE;
                            pause_cnt <= PAUSE_L;
                            exit_blk  <= 1'b1;
                        end else if (run_cnt <= 9'd1) begin
                            state     <= PAUSE;
                            pause_cnt <= PAUSE_L;
                            exit_blk  <= 1'b0;
                        end else begin
                            mv <= onehot(dir);
                        end
                    end
                    PAUSE: begin
                        pause_cnt <= pause_cnt - 8'd1;
                        if (pause_cnt <= 8'd1) begin
                            state   <= DRIVE;
                            dir     <= pdir;
                            run_cnt <= run_load;
                            blk_cnt <= 4'd0;
                            mv      <= onehot(pdir);
                        end
                    end
                    default: state <= SPAWN_WAIT;
                endcase
            end
        end
    end

    assign move_up    = mv[0];
    assign move_down  = mv[1];
    assign move_left  = mv[2];
    assign move_right = mv[3];
    assign ai_state   = state;

endmodule

// File: tb/tb_enemy_tank_ai.sv
// Directed-vector bench for enemy_tank_ai with a reference LFSR model.
module tb_enemy_tank_ai;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       enable;
    logic       dead;
    logic       got_hit;
    logic       blocked;
    logic [9:0] tank_x;
    logic [9:0] tank_y;
    logic [3:0] tank_dir;
    logic       bullet_active;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic       move_up;
    logic       move_down;
    logic       move_left;
    logic       move_right;
    logic       fire;
    logic [1:0] ai_state;
    logic [3:0] mv_o;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] m;
    logic [15:0] pre;
    logic [15:0] spawn_pre;
    logic [1:0]  cur_dir;
    logic [3:0]  first_mv;

    enemy_tank_ai #(
        .SEED(16'hACE1),
        .SPAWN_DELAY(5),
        .MIN_RUN(3),
        .PAUSE_LEN(4),
        .BLOCK_LIMIT(2),
        .FIRE_PERIOD(10),
        .ALIGN_TOL(8)
    ) dut (
        .frame_clk(frame_clk),
        .Reset(Reset),
        .enable(enable),
        .dead(dead),
        .got_hit(got_hit),
        .blocked(blocked),
        .tank_x(tank_x),
        .tank_y(tank_y),
        .tank_dir(tank_dir),
        .bullet_active(bullet_active),
        .player_x(player_x),
        .player_y(player_y),
        .move_up(move_up),
        .move_down(move_down),
        .move_left(move_left),
        .move_right(move_right),
        .fire(fire),
        .ai_state(ai_state)
    );

    assign mv_o = {move_right, move_left, move_down, move_up};

    always #5 frame_clk = ~frame_clk;

    function automatic logic [15:0] lnext(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [3:0] oh(input logic [1:0] d);
        return 4'b0001 << d;
    endfunction

    task automatic tick();
        pre = m;
        @(posedge frame_clk);
        if (enable && !Reset) m = lnext(m);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; enable = 1'b0; dead = 1'b0; got_hit = 1'b0;
        blocked = 1'b0; bullet_active = 1'b0;
        tank_x = 10'd100; tank_y = 10'd100; tank_dir = 4'b0001;
        player_x = 10'd600; player_y = 10'd400;
        m = 16'hACE1;
        tick(); tick();
        checks++;
        if (mv_o !== 4'b0000 || fire !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got mv=%b fire=%b want 0000/0", mv_o, fire);
        end
        checks++;
        if (ai_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d want 0", ai_state);
        end
        Reset = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_spawn();
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (mv_o !== 4'b0000 || fire !== 1'b0 || ai_state !== 2'd0) begin
                errors++;
                $display("FAIL spawn_idle[%0d]: got mv=%b fire=%b st=%0d want 0000/0/0",
                         i, mv_o, fire, ai_state);
            end
        end
        tick();
        spawn_pre = pre;
        cur_dir = pre[1:0];
        first_mv = oh(pre[1:0]);
        checks++;
        if (mv_o !== first_mv || ai_state !== 2'd1) begin
            errors++;
            $display("FAIL spawn_move: got mv=%b st=%0d want mv=%b st=1",
                     mv_o, ai_state, first_mv);
        end
    endtask

    task automatic test_run_pause();
        int len;
        len = 3 + int'(spawn_pre[6:0]);
        for (int i = 1; i < len; i++) begin
            tick();
            checks++;
            if (mv_o !== oh(cur_dir) || ai_state !== 2'd1) begin
                errors++;
                $display("FAIL run_hold[%0d]: got mv=%b st=%0d want mv=%b st=1",
                         i, mv_o, ai_state, oh(cur_dir));
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (mv_o !== 4'b0000 || ai_state !== 2'd2) begin
                errors++;
                $display("FAIL pause[%0d]: got mv=%b st=%0d want 0000/2",
                         i, mv_o, ai_state);
            end
        end
        tick();
        cur_dir = pre[1:0];
        checks++;
        if (mv_o !== oh(cur_dir) || ai_state !== 2'd1) begin
            errors++;
            $display("FAIL pause_exit: got mv=%b st=%0d want mv=%b st=1",
                     mv_o, ai_state, oh(cur_dir));
        end
    endtask

    task automatic test_block();
        logic [1:0] exp_dir;
        blocked = 1'b1;
        for (int r = 0; r < 200; r++) begin
            tick();
            checks++;
            if (mv_o !== oh(cur_dir) || ai_state !== 2'd1) begin
                errors++;
                $display("FAIL blk_first[%0d]: got mv=%b st=%0d want mv=%b st=1",
                         r, mv_o, ai_state, oh(cur_dir));
            end
            tick();
            checks++;
            if (mv_o !== 4'b0000 || ai_state !== 2'd2) begin
                errors++;
                $display("FAIL blk_pause[%0d]: got mv=%b st=%0d want 0000/2",
                         r, mv_o, ai_state);
            end
            tick(); tick(); tick();
            tick();
            exp_dir = (pre[1:0] == cur_dir) ? cur_dir + 2'd1 : pre[1:0];
            checks++;
            if (mv_o !== oh(exp_dir) || ai_state !== 2'd1) begin
                errors++;
                $display("FAIL blk_newdir[%0d]: got mv=%b st=%0d want mv=%b (old %b)",
                         r, mv_o, ai_state, oh(exp_dir), oh(cur_dir));
            end
            cur_dir = exp_dir;
        end
        blocked = 1'b0;
    endtask

    task automatic test_hit();
        got_hit = 1'b1;
        tick();
        got_hit = 1'b0;
        checks++;
        if (mv_o !== 4'b0000 || fire !== 1'b0 || ai_state !== 2'd0) begin
            errors++;
            $display("FAIL hit_clear: got mv=%b fire=%b st=%0d want 0000/0/0",
                     mv_o, fire, ai_state);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (mv_o !== 4'b0000 || ai_state !== 2'd0) begin
                errors++;
                $display("FAIL hit_wait[%0d]: got mv=%b st=%0d want 0000/0",
                         i, mv_o, ai_state);
            end
        end
        tick();
        cur_dir = pre[1:0];
        checks++;
        if (mv_o !== oh(cur_dir) || ai_state !== 2'd1) begin
            errors++;
            $display("FAIL hit_respawn: got mv=%b st=%0d want mv=%b st=1",
                     mv_o, ai_state, oh(cur_dir));
        end
    endtask

    task automatic test_periodic_fire();
        for (int c = 0; c < 3; c++) begin
            for (int i = 1; i <= 10; i++) begin
                tick();
                checks++;
                if (fire !== (i == 10)) begin
                    errors++;
                    $display("FAIL fire_period[%0d.%0d]: got %b want %b",
                             c, i, fire, (i == 10));
                end
            end
        end
        bullet_active = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            checks++;
            if (fire !== 1'b0) begin
                errors++;
                $display("FAIL fire_bullet[%0d]: got %b want 0", i, fire);
            end
        end
    endtask

    task automatic test_aimed_fire();
        tank_x = 10'd200; tank_y = 10'd300; tank_dir = 4'b0001;
        player_x = 10'd220; player_y = 10'd100;
        bullet_active = 1'b0;
        tick();
        checks++;
        if (fire !== 1'b1) begin
            errors++;
            $display("FAIL fire_release: got %b want 1", fire);
        end
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (fire !== 1'b0) begin
                errors++;
                $display("FAIL aim_outside[%0d]: got %b want 0", i, fire);
            end
        end
        player_x = 10'd205;
        tick();
        checks++;
        if (fire !== 1'b1) begin
            errors++;
            $display("FAIL aim_fire: got %b want 1", fire);
        end
        tick();
        checks++;
        if (fire !== 1'b0) begin
            errors++;
            $display("FAIL aim_width: got %b want 0", fire);
        end
        tank_x = 10'd100; tank_y = 10'd100;
        player_x = 10'd600; player_y = 10'd400;
    endtask

    task automatic test_dead();
        dead = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (mv_o !== 4'b0000 || fire !== 1'b0 || ai_state !== 2'd0) begin
                errors++;
                $display("FAIL dead_hold[%0d]: got mv=%b fire=%b st=%0d want 0000/0/0",
                         i, mv_o, fire, ai_state);
            end
        end
        dead = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        tick();
        cur_dir = pre[1:0];
        checks++;
        if (mv_o !== oh(cur_dir) || ai_state !== 2'd1) begin
            errors++;
            $display("FAIL dead_release: got mv=%b st=%0d want mv=%b st=1",
                     mv_o, ai_state, oh(cur_dir));
        end
    endtask

    task automatic test_async_reset();
        #3;
        Reset = 1'b1;
        #1;
        checks++;
        if (mv_o !== 4'b0000 || fire !== 1'b0 || ai_state !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got mv=%b fire=%b st=%0d want 0000/0/0",
                     mv_o, fire, ai_state);
        end
        m = 16'hACE1;
        enable = 1'b0;
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (mv_o !== 4'b0000 || ai_state !== 2'd0) begin
                errors++;
                $display("FAIL disabled[%0d]: got mv=%b st=%0d want 0000/0",
                         i, mv_o, ai_state);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tick();
        checks++;
        if (mv_o !== first_mv || mv_o !== oh(pre[1:0]) || ai_state !== 2'd1) begin
            errors++;
            $display("FAIL reset_respawn: got mv=%b st=%0d want mv=%b st=1",
                     mv_o, ai_state, first_mv);
        end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_run_pause();
        test_block();
        test_hit();
        test_periodic_fire();
        test_aimed_fire();
        test_dead();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
